// File: rtl/puf_host_16_32.sv
// Host-side UART initiator for the PUF link: sends a 16-bit challenge as two
// 8N1 frames, then collects four 8N1 frames into a 32-bit response.
module puf_host_16_32 #(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_CLKS = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] challenge,
    output logic        busy,
    output logic        tx_out,
    input  logic        rx,
    output logic [31:0] response,
    output logic        resp_valid,
    output logic        timeout,
    output logic        frame_err
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(TIMEOUT_CLKS);
    localparam logic [4:0]       TX_LAST   = 5'd19;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX,
        S_RX_HUNT,
        S_RX_START,
        S_RX_DATA,
        S_RX_STOP
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] clk_cnt_q;
    logic [4:0]       bit_idx_q;
    logic [1:0]       byte_idx_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic [18:0]      tx_shift_q;
    logic             tx_q;
    logic             busy_q;
    logic             rx_meta_q;
    logic             rx_sync_q;
    logic             rx_prev_q;
    logic [7:0]       rx_byte_q;
    logic [23:0]      rx_word_q;
    logic [31:0]      response_q;
    logic             resp_valid_q;
    logic             timeout_q;
    logic             frame_err_q;

    logic rx_fall;
    logic bit_done;

    assign rx_fall  = rx_prev_q & ~rx_sync_q;
    assign bit_done = (clk_cnt_q == BIT_LAST);

    // Two-flop synchronizer plus edge-detect register; idle level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // NOTE: every register below is assigned with <= so all branches see the
    // values from the start of the cycle, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            clk_cnt_q    <= '0;
            bit_idx_q    <= '0;
            byte_idx_q   <= '0;
            to_cnt_q     <= '0;
            tx_shift_q   <= '1;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            rx_byte_q    <= '0;
            rx_word_q    <= '0;
            response_q   <= '0;
            resp_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            frame_err_q  <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (start) begin
                        // Start bit goes out next cycle; the shifter holds the
                        // remaining 19 bits of both frames, LSB first.
                        state_q    <= S_TX;
                        busy_q     <= 1'b1;
                        tx_q       <= 1'b0;
                        tx_shift_q <= {1'b1, challenge[15:8], 1'b0,
                                       1'b1, challenge[7:0]};
                        clk_cnt_q  <= '0;
                        bit_idx_q  <= '0;
                    end
                end

                S_TX: begin
                    if (bit_done) begin
                        clk_cnt_q <= '0;
                        if (bit_idx_q == TX_LAST) begin
                            tx_q       <= 1'b1;
                            state_q    <= S_RX_HUNT;
                            to_cnt_q   <= '0;
                            byte_idx_q <= '0;
                            rx_word_q  <= '0;
                        end else begin
                            tx_q       <= tx_shift_q[0];
                            tx_shift_q <= {1'b1, tx_shift_q[18:1]};
                            bit_idx_q  <= bit_idx_q + 5'd1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end

                S_RX_HUNT: begin
                    if (to_cnt_q == TO_LIMIT) begin
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                        if (rx_fall) begin
                            state_q   <= S_RX_START;
                            clk_cnt_q <= '0;
                        end
                    end
                end

                S_RX_START: begin
                    if (clk_cnt_q == HALF_LAST) begin
                        clk_cnt_q <= '0;
                        bit_idx_q <= '0;
                        // A line that is high again at mid-bit was a glitch.
                        state_q   <= rx_sync_q ? S_RX_HUNT : S_RX_DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end

                S_RX_DATA: begin
                    if (bit_done) begin
                        clk_cnt_q <= '0;
                        rx_byte_q <= {rx_sync_q, rx_byte_q[7:1]};
                        if (bit_idx_q == 5'd7) begin
                            state_q <= S_RX_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 5'd1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end

                S_RX_STOP: begin
                    if (bit_done) begin
                        clk_cnt_q <= '0;
                        if (!rx_sync_q) begin
                            frame_err_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= S_IDLE;
                        end else if (byte_idx_q != 2'd3) begin
                            // Bytes arrive low first, so shift them down.
                            rx_word_q  <= {rx_byte_q, rx_word_q[23:8]};
                            byte_idx_q <= byte_idx_q + 2'd1;
                            to_cnt_q   <= '0;
                            state_q    <= S_RX_HUNT;
                        end else begin
                            response_q   <= {rx_byte_q, rx_word_q};
                            resp_valid_q <= 1'b1;
                            busy_q       <= 1'b0;
                            state_q      <= S_IDLE;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign tx_out     = tx_q;
    assign response   = response_q;
    assign resp_valid = resp_valid_q;
    assign timeout    = timeout_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_puf_host_16_32.sv
// Scoreboard bench for puf_host_16_32: checks challenge framing, response
// assembly, timeout, framing error, glitch rejection and reset behaviour.
module tb_puf_host_16_32;

    localparam int CPB = 16;
    localparam int TO  = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] challenge = '0;
    logic        rx = 1'b1;
    logic        busy;
    logic        tx_out;
    logic [31:0] response;
    logic        resp_valid;
    logic        timeout;
    logic        frame_err;

    always #5 clk = ~clk;

    puf_host_16_32 #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .challenge (challenge),
        .busy      (busy),
        .tx_out    (tx_out),
        .rx        (rx),
        .response  (response),
        .resp_valid(resp_valid),
        .timeout   (timeout),
        .frame_err (frame_err)
    );

    typedef enum logic [1:0] {EV_RESP, EV_TIMEOUT, EV_FERR} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        logic [31:0] data;
    } ev_t;

    ev_t         exp_ev_q[$];
    logic [7:0]  exp_tx_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] model_resp = '0;
    logic        prev_busy = 1'b0;
    ev_t         mon_e;
    ev_kind_e    mon_kind;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Event monitor: every pulse pops one expected event off the scoreboard.
    initial forever begin
        tick();
        if (resp_valid || timeout || frame_err) begin
            check("pulse_onehot", 32'($countones({resp_valid, timeout, frame_err})), 32'd1);
            check("busy_at_pulse", {31'd0, busy}, 32'd0);
            check("busy_before_pulse", {31'd0, prev_busy}, 32'd1);
            mon_kind = resp_valid ? EV_RESP : (timeout ? EV_TIMEOUT : EV_FERR);
            if (exp_ev_q.size() == 0) begin
                check("unexpected_pulse", {29'd0, resp_valid, timeout, frame_err}, 32'd0);
            end else begin
                mon_e = exp_ev_q.pop_front();
                check("event_kind", 32'(mon_kind), 32'(mon_e.kind));
                check("response_at_event", response, mon_e.data);
            end
        end
        prev_busy = busy;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic issue_start(input logic [15:0] ch);
        tick();
        start = 1'b1;
        challenge = ch;
        tick();
        start = 1'b0;
    endtask

    // Samples every TX cycle; returns one cycle into RX_HUNT.
    task automatic tx_capture(input int inject_at);
        logic [7:0]  b0, b1;
        logic [19:0] exp_bits, got_bits;
        int          dev, busy_low;
        b0 = exp_tx_q.pop_front();
        b1 = exp_tx_q.pop_front();
        exp_bits = {1'b1, b1, 1'b0, 1'b1, b0, 1'b0};
        got_bits = '0;
        dev = 0;
        busy_low = 0;
        for (int i = 0; i < 20 * CPB; i++) begin
            if (i > 0) tick();
            if (tx_out !== exp_bits[i / CPB]) dev++;
            if (i % CPB == CPB / 2) got_bits[i / CPB] = tx_out;
            if (busy !== 1'b1) busy_low++;
            if (i == inject_at) begin
                start = 1'b1;
                challenge = 16'h1234;
            end
            if (i == inject_at + 1) start = 1'b0;
        end
        check("tx_byte0", {24'd0, got_bits[8:1]}, {24'd0, b0});
        check("tx_byte1", {24'd0, got_bits[18:11]}, {24'd0, b1});
        check("tx_frame_bits", {12'd0, got_bits}, {12'd0, exp_bits});
        check("tx_bit_timing", 32'(dev), 32'd0);
        check("busy_during_tx", 32'(busy_low), 32'd0);
        tick();
        check("tx_idle_after", {31'd0, tx_out}, 32'd1);
        check("busy_in_hunt", {31'd0, busy}, 32'd1);
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (CPB) tick();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic idle_line(input int n);
        rx = 1'b1;
        repeat (n) tick();
    endtask

    task automatic send_reply(input logic [31:0] word, input int lead);
        idle_line(lead);
        for (int k = 0; k < 4; k++) begin
            send_frame(word[8*k +: 8], 1'b1);
            if (k < 3) idle_line(3 * CPB);
        end
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while ((exp_ev_q.size() != 0 || busy) && k < 3000) begin
            tick();
            k++;
        end
        check("done_within_budget", 32'(k >= 3000), 32'd0);
        repeat (3) tick();
    endtask

    initial begin
        int k;

        // Reset state.
        repeat (3) tick();
        check("rst_tx_out", {31'd0, tx_out}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_response", response, 32'd0);
        check("rst_pulses", {29'd0, resp_valid, timeout, frame_err}, 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Challenge 0xA55A with a second start during TX; device silent.
        exp_tx_q.push_back(8'h5A);
        exp_tx_q.push_back(8'hA5);
        exp_ev_q.push_back('{EV_TIMEOUT, model_resp});
        issue_start(16'hA55A);
        tx_capture(100);
        k = 0;
        while (!timeout && k < 200) begin
            tick();
            k++;
        end
        check("timeout_latency", 32'(k), 32'd101);
        check("resp_after_timeout", response, model_resp);
        wait_done();

        // Full round trip.
        exp_tx_q.push_back(8'hE1);
        exp_tx_q.push_back(8'hC3);
        exp_ev_q.push_back('{EV_RESP, 32'hDEAD_BEEF});
        issue_start(16'hC3E1);
        tx_capture(-1);
        send_reply(32'hDEAD_BEEF, 20);
        model_resp = 32'hDEAD_BEEF;
        wait_done();
        check("resp_hold_1", response, model_resp);

        // Framing error on byte 1.
        exp_tx_q.push_back(8'h01);
        exp_tx_q.push_back(8'h00);
        exp_ev_q.push_back('{EV_FERR, model_resp});
        issue_start(16'h0001);
        tx_capture(-1);
        idle_line(10);
        send_frame(8'h11, 1'b1);
        idle_line(3 * CPB);
        send_frame(8'h22, 1'b0);
        wait_done();
        check("resp_after_ferr", response, model_resp);

        // Short low glitch ahead of a valid reply.
        exp_tx_q.push_back(8'h81);
        exp_tx_q.push_back(8'h7E);
        exp_ev_q.push_back('{EV_RESP, 32'h1234_5678});
        issue_start(16'h7E81);
        tx_capture(-1);
        idle_line(10);
        rx = 1'b0;
        repeat (3) tick();
        send_reply(32'h1234_5678, 30);
        model_resp = 32'h1234_5678;
        wait_done();
        check("resp_hold_2", response, model_resp);

        // Reset in the middle of TX.
        issue_start(16'h5555);
        repeat (50) tick();
        rst = 1'b1;
        tick();
        check("midrst_tx_out", {31'd0, tx_out}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_response", response, 32'd0);
        rst = 1'b0;
        model_resp = '0;
        repeat (5) tick();

        // Normal transaction after the reset.
        exp_tx_q.push_back(8'hF0);
        exp_tx_q.push_back(8'h0F);
        exp_ev_q.push_back('{EV_RESP, 32'h0123_4567});
        issue_start(16'h0FF0);
        tx_capture(-1);
        send_reply(32'h0123_4567, 5);
        model_resp = 32'h0123_4567;
        wait_done();
        check("resp_final", response, model_resp);

        check("ev_queue_empty", 32'(exp_ev_q.size()), 32'd0);
        check("tx_queue_empty", 32'(exp_tx_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
